// File: rtl/ceu_div_sequencer.sv
// Batch divide sequencer: issues N_ELEM divisions against a common denominator, collects quotients.
// Optional WAIT timeout enabled by macro CEU_DIV_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | waiting for start, operands latched on start
// S_ISSUE | div_valid high, operands for element idx presented
// S_WAIT  | waiting for div_finish for element idx
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module ceu_div_sequencer #(
  parameter int DBL_WIDTH      = 64,
  parameter int N_ELEM         = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_ELEM*DBL_WIDTH-1:0] num_vec,
  input  logic [DBL_WIDTH-1:0]        den,
  output logic                        div_valid,
  output logic [DBL_WIDTH-1:0]        div_numerator,
  output logic [DBL_WIDTH-1:0]        div_denominator,
  input  logic                        div_finish,
  input  logic [DBL_WIDTH-1:0]        div_quotient,
  output logic [N_ELEM*DBL_WIDTH-1:0] q_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  output logic                        den_zero
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                      state;
  logic [N_ELEM*DBL_WIDTH-1:0] num_r;
  logic [DBL_WIDTH-1:0]        den_r;
  logic [IDX_W-1:0]            idx;

  // idx only moves on a finish, so the operands stay put for the whole request
  assign div_numerator   = num_r[int'(idx)*DBL_WIDTH +: DBL_WIDTH];
  assign div_denominator = den_r;

`ifdef CEU_DIV_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      num_r     <= '0;
      den_r     <= '0;
      q_vec     <= '0;
      div_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      den_zero  <= 1'b0;
`ifdef CEU_DIV_TIMEOUT_EN
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      div_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_r     <= num_vec;
            den_r     <= den;
            den_zero  <= (den[DBL_WIDTH-2:0] == '0);
            idx       <= '0;
            div_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
`ifdef CEU_DIV_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef CEU_DIV_TIMEOUT_EN
          // down-counter reaches zero on the last permitted WAIT cycle
          tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (div_finish) begin
            q_vec[int'(idx)*DBL_WIDTH +: DBL_WIDTH] <= div_quotient;
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              idx       <= idx + 1'b1;
              div_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          end
`ifdef CEU_DIV_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
